// File: rtl/fifo_apb_pkg.sv
// Shared types and header-word decoding for the FIFO-to-APB command master.
// A header word carries the direction bit, a reserved field and the APB address.
package fifo_apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } fifo_apb_state_e;

  localparam int HDR_WRITE_BIT  = 31;
  localparam int HDR_RSVD_HI    = 30;
  localparam int HDR_RSVD_LO    = 28;
  localparam int HDR_ADDR_MAX_W = HDR_RSVD_LO;

  typedef struct packed {
    logic                      write;
    logic [2:0]                rsvd;
    logic [HDR_ADDR_MAX_W-1:0] addr;
  } fifo_apb_hdr_t;

  // The reserved field is extracted only so callers can explicitly ignore it.
  function automatic fifo_apb_hdr_t decode_header(input logic [31:0] word);
    fifo_apb_hdr_t h;
    h.write = word[HDR_WRITE_BIT];
    h.rsvd  = word[HDR_RSVD_HI:HDR_RSVD_LO];
    h.addr  = word[HDR_ADDR_MAX_W-1:0];
    return h;
  endfunction

endpackage

// File: rtl/fifo_apb_watchdog.sv
// Saturating pready watchdog: counts stalled ACCESS cycles and flags the cycle in
// which the count reaches TIMEOUT. TIMEOUT=0 disables it.
module fifo_apb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST_CNT = (TIMEOUT < 1) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && (count != MAX_CNT)) begin
      count <= count + 1'b1;
    end
  end

  // Fires in the stalled cycle whose increment would make the count equal TIMEOUT.
  assign expired = (TIMEOUT > 0) && count_en && (count == LAST_CNT);

endmodule

// File: rtl/fifo_apb_master.sv
// Pops command words from a show-ahead FIFO, runs one APB3 transfer per command
// and returns a single response per command on a valid/ready channel.
module fifo_apb_master
  import fifo_apb_pkg::*;
#(
  parameter int DSIZE   = 32,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              read_clk,
  input  logic              read_reset_n,
  input  logic [DSIZE-1:0]  read_data,
  input  logic              read_empty,
  output logic              read_enable,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DSIZE-1:0]  pwdata,
  input  logic [DSIZE-1:0]  prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DSIZE-1:0]  resp_data,
  output logic              resp_err,
  output logic              resp_timeout,
  output logic              busy
);

  // Response handshake: a response transfers on a rising edge where resp_valid
  // and resp_ready are both 1; once raised, resp_valid and the resp_* payload
  // stay constant until that edge, and resp_ready alone has no effect.

  fifo_apb_state_e state;
  fifo_apb_hdr_t   hdr;
  logic            wd_clear;
  logic            wd_count_en;
  logic            wd_expired;
  logic            unused_hdr_bits;

  assign hdr             = decode_header(read_data);
  assign unused_hdr_bits = ^{hdr.rsvd, hdr.addr};

  assign read_enable = ((state == ST_IDLE) || (state == ST_WDATA)) &&
                       !read_empty && read_reset_n;
  assign busy        = (state != ST_IDLE);

  // The counter restarts on the SETUP->ACCESS edge and only runs while stalled.
  assign wd_clear    = (state == ST_SETUP);
  assign wd_count_en = (state == ST_ACCESS) && !pready;

  fifo_apb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (read_clk),
    .rst_n    (read_reset_n),
    .clear    (wd_clear),
    .count_en (wd_count_en),
    .expired  (wd_expired)
  );

  always_ff @(posedge read_clk or negedge read_reset_n) begin
    if (!read_reset_n) begin
      state        <= ST_IDLE;
      paddr        <= '0;
      pwrite       <= 1'b0;
      pwdata       <= '0;
      psel         <= 1'b0;
      penable      <= 1'b0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_err     <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (read_enable) begin
            paddr  <= hdr.addr[ADDR_W-1:0];
            pwrite <= hdr.write;
            if (hdr.write) begin
              state <= ST_WDATA;
            end else begin
              state <= ST_SETUP;
              psel  <= 1'b1;
            end
          end
        end

        ST_WDATA: begin
          if (read_enable) begin
            pwdata <= read_data;
            state  <= ST_SETUP;
            psel   <= 1'b1;
          end
        end

        ST_SETUP: begin
          penable <= 1'b1;
          state   <= ST_ACCESS;
        end

        // Completion wins over expiry when both land in the same cycle.
        ST_ACCESS: begin
          if (pready) begin
            psel         <= 1'b0;
            penable      <= 1'b0;
            resp_valid   <= 1'b1;
            resp_data    <= pwrite ? '0 : prdata;
            resp_err     <= pslverr;
            resp_timeout <= 1'b0;
            state        <= ST_RESP;
          end else if (wd_expired) begin
            psel         <= 1'b0;
            penable      <= 1'b0;
            resp_valid   <= 1'b1;
            resp_data    <= '0;
            resp_err     <= 1'b1;
            resp_timeout <= 1'b1;
            state        <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_apb_master.md
Name: fifo_apb_master

Overview:
- Sits directly downstream of the read side of async_fifo, in the read_clk domain.
- Pops command words from the FIFO, decodes them, and drives APB3 read or write transfers.
- Returns one response per command on a valid/ready interface.
- Contains a command-decode FSM, an APB setup/access sequencer and a pready watchdog.

Parameters:
- DSIZE, 32, FIFO word width and APB data width (must be 32).
- ADDR_W, 16, APB address width (must be ≤ 28).
- TIMEOUT, 255, maximum ACCESS cycles waiting for pready; 0 disables the watchdog.

Ports:
- read_clk  in  1  clock, shared with the FIFO read side.
- read_reset_n  in  1  asynchronous active-low reset.
- read_data  in  DSIZE  FIFO head word; valid whenever read_empty=0 (show-ahead).
- read_empty  in  1  FIFO empty.
- read_enable  out  1  pop strobe; the head word is consumed at the edge where it is 1.
- paddr  out  ADDR_W  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction, 1=write.
- pwdata  out  DSIZE  APB write data.
- prdata  in  DSIZE  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accepted.
- resp_data  out  DSIZE  prdata for reads; 0 for writes.
- resp_err  out  1  pslverr, or watchdog timeout.
- resp_timeout  out  1  the response was terminated by the watchdog.
- busy  out  1  state != IDLE.

Behaviour:
- Header word format:
  - bit31 = write.
  - bits30:28 = reserved; ignored, and software writes 0.
  - bits ADDR_W-1:0 = paddr.
- A write command is two words: the header, then the data word. A read command is the header only.
- read_enable = (state==IDLE || state==WDATA) && !read_empty && read_reset_n. It is combinational and never asserted in any other state.
- FSM states: IDLE, WDATA, SETUP, ACCESS, RESP.
  - IDLE: on a pop, latch the header. A write header goes to WDATA; a read header goes to SETUP.
  - WDATA: wait for !read_empty. On the pop, latch pwdata and go to SETUP. Any wait in WDATA is legal and indefinite.
  - SETUP: psel=1, penable=0 for exactly one cycle; paddr and pwrite are stable. Next state is ACCESS.
  - ACCESS: psel=1, penable=1. On pready=1, capture prdata (reads only) and pslverr into the response registers; drop psel and penable the next cycle; go to RESP.
  - RESP: resp_valid=1, and the response registers are held until resp_ready=1. Then go to IDLE. The next header may pop in the first IDLE cycle, so there is no extra bubble.
- paddr, pwrite and pwdata hold their last values outside a transfer.
- Watchdog:
  - The counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT with pready still 0: abort to RESP with resp_err=1, resp_timeout=1, resp_data=0. psel and penable deassert the next cycle.
  - pready=1 in the same cycle the count reaches TIMEOUT counts as completion, not timeout.
  - The counter is sized $clog2(TIMEOUT+1) bits and must not wrap.
- Latency with pready=1 in the first ACCESS cycle:
  - Read: header pop at edge 0, SETUP in cycle 1, ACCESS in cycle 2, resp_valid from cycle 3.
  - Write: pops at edges 0 and 1, resp_valid from cycle 4.
- Strictly one outstanding command; there is no pipelining across commands.
- Reset values: all outputs 0, state IDLE, counter 0.
- Reset mid-operation:
  - psel, penable and resp_valid drop asynchronously.
  - A partially popped command is discarded; the FIFO is reset in the same domain.
- resp_ready while resp_valid=0 is ignored.

Decomposition:
- Package fifo_apb_pkg holds:
  - the state enum;
  - HDR_WRITE_BIT=31;
  - the reserved-field localparams;
  - a header-decode function.
- One sub-module, fifo_apb_watchdog, takes inputs clear, count_en and TIMEOUT and outputs expired.
- All other logic stays in fifo_apb_master.

Test Plan:
- Read: push header 32'h0000_1234, pready=1, prdata=32'hDEAD_BEEF.
  - Required: paddr=16'h1234 and pwrite=0 in SETUP.
  - resp_valid in cycle 3 with resp_data=32'hDEAD_BEEF and resp_err=0.
- Write with a delayed data word: push header 32'h8000_00A0, then 32'hCAFE_0001 four cycles later.
  - Required: busy=1 and psel=0 while in WDATA.
  - On the APB transfer, pwdata=32'hCAFE_0001 and pwrite=1; resp_data=0.
- Wait states plus error: read of 16'h0010 with pready low for 3 ACCESS cycles, then pready=1 and pslverr=1.
  - Required: penable=1 for 4 cycles.
  - resp_err=1, resp_timeout=0.
- Timeout: TIMEOUT=8, pready tied 0.
  - Required: ACCESS lasts exactly 8 cycles.
  - resp_err=1, resp_timeout=1, then psel=0.
- Backpressure plus back-to-back: 3 queued reads, resp_ready held 0 for 5 cycles.
  - Required: resp_valid stable with data held; read_enable stays 0 until the handshake.
  - The next header pops in the cycle after resp_ready=1.
- Mid-transfer reset: assert read_reset_n=0 during ACCESS.
  - Required: psel, penable and resp_valid go to 0 immediately.
  - After release, the FIFO is refilled and the next command completes normally.
